// File: rtl/image_pkg.sv
// Shared types for the image write path: pixel-pair payload and write-controller states.
package image_pkg;

  localparam int unsigned PIX_PAIR_W = 48;

  // R0/G0/B0 is the left (odd) pixel, R1/G1/B1 the right one.
  typedef struct packed {
    logic [7:0] r0;
    logic [7:0] g0;
    logic [7:0] b0;
    logic [7:0] r1;
    logic [7:0] g1;
    logic [7:0] b1;
  } pix_pair_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    DONE   = 2'd3
  } wr_ctrl_state_e;

endpackage

// File: rtl/image_write_ctrl_if.sv
// Pixel-pair stream into the write controller and the addressed write strobe out of it.
interface image_write_ctrl_if
  import image_pkg::*;
#(
  parameter int unsigned ROW_W = 9,
  parameter int unsigned COL_W = 9
);

  logic             in_valid;
  logic             in_ready;
  pix_pair_t        in_pix;
  logic             wr_hsync;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  pix_pair_t        wr_pix;

  // master: upstream filter plus frame writer; slave: the write controller
  modport master (
    output in_valid, in_pix,
    input  in_ready, wr_hsync, wr_row, wr_col, wr_pix
  );

  modport slave (
    input  in_valid, in_pix,
    output in_ready, wr_hsync, wr_row, wr_col, wr_pix
  );

endinterface

// File: rtl/frame_pos_counter.sv
// Column/row position within a frame, with last-column/last-row flags.
// IMG_WR_CTRL_VFLIP_EN: row address is mirrored (HEIGHT-1-row) for bottom-up storage.
module frame_pos_counter #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned ROW_W  = $clog2(HEIGHT),
  parameter int unsigned COL_W  = $clog2(WIDTH / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [COL_W-1:0] col_q,
  output logic [ROW_W-1:0] row_addr_c,
  output logic             last_col_c,
  output logic             last_row_c
);

  localparam int unsigned COL_LAST = WIDTH / 2 - 1;
  localparam int unsigned ROW_LAST = HEIGHT - 1;

  logic [COL_W-1:0] col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign last_col_c = (col_q == COL_W'(COL_LAST));
  assign last_row_c = (row_q == ROW_W'(ROW_LAST));

`ifdef IMG_WR_CTRL_VFLIP_EN
  assign row_addr_c = ROW_W'(ROW_LAST) - row_q;
`else
  assign row_addr_c = row_q;
`endif

  // Advance column, roll into the next row, wrap to origin after the last pair.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (!last_col_c) begin
        col_d = col_q + COL_W'(1);
      end else begin
        col_d = '0;
        row_d = last_row_c ? '0 : row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/image_write_ctrl.sv
// Sequences pixel pairs into the frame writer with row blanking and an end-of-frame pulse.
// IMG_WR_CTRL_VFLIP_EN: rows are addressed bottom-up (wr_row resets to HEIGHT-1).
module image_write_ctrl #(
  parameter int unsigned WIDTH  = 768,
  parameter int unsigned HEIGHT = 512,
  parameter int unsigned HBLANK = 4,
  parameter int unsigned ROW_W  = $clog2(HEIGHT),
  parameter int unsigned COL_W  = $clog2(WIDTH / 2)
) (
  input  logic                                     HCLK,
  input  logic                                     HRESET,
  input  logic                                     start,
  image_write_ctrl_if.slave                        bus,
  output logic                                     busy,
  output logic                                     frame_done,
  output logic [$clog2(WIDTH*HEIGHT/2+1)-1:0]      pair_count
);

  localparam int unsigned PC_W    = $clog2(WIDTH * HEIGHT / 2 + 1);
  localparam int unsigned PC_MAX  = WIDTH * HEIGHT / 2;
  localparam int unsigned BL_W    = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int unsigned BL_LAST = (HBLANK > 0) ? HBLANK - 1 : 0;
`ifdef IMG_WR_CTRL_VFLIP_EN
  localparam logic [ROW_W-1:0] ROW_RST = ROW_W'(HEIGHT - 1);
`else
  localparam logic [ROW_W-1:0] ROW_RST = '0;
`endif

  image_pkg::wr_ctrl_state_e state_q, state_d;
  logic [BL_W-1:0]           blank_q, blank_d;
  logic                      wr_hsync_q, wr_hsync_d;
  logic [ROW_W-1:0]          wr_row_q, wr_row_d;
  logic [COL_W-1:0]          wr_col_q, wr_col_d;
  image_pkg::pix_pair_t      wr_pix_q, wr_pix_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;
  logic [PC_W-1:0]           pair_count_q, pair_count_d;

  logic                      start_ok_c;
  logic                      accept_c;
  logic [COL_W-1:0]          col_q;
  logic [ROW_W-1:0]          row_addr_c;
  logic                      last_col_c;
  logic                      last_row_c;

  // The frame_done cycle still reports busy, so a start there is dropped too.
  assign start_ok_c  = (state_q == image_pkg::IDLE) && start && !frame_done_q;
  assign bus.in_ready = (state_q == image_pkg::ACTIVE);
  assign accept_c    = bus.in_valid && (state_q == image_pkg::ACTIVE);

  frame_pos_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_pos (
    .clk       (HCLK),
    .rst       (HRESET),
    .clr       (start_ok_c),
    .adv       (accept_c),
    .col_q     (col_q),
    .row_addr_c(row_addr_c),
    .last_col_c(last_col_c),
    .last_row_c(last_row_c)
  );

  // Next state, write-port capture and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    blank_d      = blank_q;
    wr_hsync_d   = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_pix_d     = wr_pix_q;
    pair_count_d = pair_count_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      image_pkg::IDLE: begin
        if (start_ok_c) begin
          state_d      = image_pkg::ACTIVE;
          blank_d      = '0;
          pair_count_d = '0;
        end
      end
      image_pkg::ACTIVE: begin
        if (accept_c) begin
          wr_hsync_d = 1'b1;
          wr_row_d   = row_addr_c;
          wr_col_d   = col_q;
          wr_pix_d   = bus.in_pix;
          if (pair_count_q != PC_W'(PC_MAX)) pair_count_d = pair_count_q + PC_W'(1);
          if (last_col_c) begin
            if (last_row_c) begin
              state_d = image_pkg::DONE;
            end else if (HBLANK != 0) begin
              state_d = image_pkg::HBLANK;
              blank_d = '0;
            end
          end
        end
      end
      image_pkg::HBLANK: begin
        if (blank_q == BL_W'(BL_LAST)) state_d = image_pkg::ACTIVE;
        else                           blank_d = blank_q + BL_W'(1);
      end
      image_pkg::DONE: begin
        state_d      = image_pkg::IDLE;
        frame_done_d = 1'b1;
      end
      default: state_d = image_pkg::IDLE;
    endcase
    busy_d = (state_d != image_pkg::IDLE) || frame_done_d;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q      <= image_pkg::IDLE;
      blank_q      <= '0;
      wr_hsync_q   <= 1'b0;
      wr_row_q     <= ROW_RST;
      wr_col_q     <= '0;
      wr_pix_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pair_count_q <= '0;
    end else begin
      state_q      <= state_d;
      blank_q      <= blank_d;
      wr_hsync_q   <= wr_hsync_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_pix_q     <= wr_pix_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign bus.wr_hsync = wr_hsync_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_pix   = wr_pix_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign pair_count   = pair_count_q;

endmodule

// File: tb/tb_image_write_ctrl.sv
// Randomized bench for image_write_ctrl on an 8x4 frame (HBLANK=2) plus an HBLANK=0 instance.
// Define IMG_WR_CTRL_VFLIP_EN to expect bottom-up row addresses.
`timescale 1ns/1ps
module tb_image_write_ctrl;
  import image_pkg::*;

  localparam int W         = 8;
  localparam int H         = 4;
  localparam int HB        = 2;
  localparam int ROW_W     = 2;
  localparam int COL_W     = 2;
  localparam int PC_W      = 5;
  localparam int ROW_PAIRS = W / 2;
  localparam int PAIRS     = W * H / 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            start, start0;
  logic            busy, frame_done, busy0, frame_done0;
  logic [PC_W-1:0] pc, pc0;
  int              vecs = 0;
  int              errs = 0;

  image_write_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus  ();
  image_write_ctrl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus0 ();

  image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(HB)) dut (
    .HCLK(clk), .HRESET(rst), .start(start), .bus(bus),
    .busy(busy), .frame_done(frame_done), .pair_count(pc)
  );

  image_write_ctrl #(.WIDTH(W), .HEIGHT(H), .HBLANK(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .start(start0), .bus(bus0),
    .busy(busy0), .frame_done(frame_done0), .pair_count(pc0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Storage address the writer should see for logical row r.
  function automatic logic [ROW_W-1:0] exp_row(input int r);
`ifdef IMG_WR_CTRL_VFLIP_EN
    return ROW_W'(H - 1 - r);
`else
    return ROW_W'(r);
`endif
  endfunction

  // One frame: random valid density, model tracks accepted pairs and the row gap.
  task automatic run_frame(input int pct, input bit poke_start, input int abort_at, input string tag);
    int         k = 0;
    int         gap = 0;
    int         cyc_n = 0;
    bit         acc;
    logic [47:0] drv;
    start = 1'b1;
    tick();
    start = 1'b0;
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL %s start_busy: got %b want 1", tag, busy); end
    vecs++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL %s start_ready: got %b want 1", tag, bus.in_ready); end
    while (k < PAIRS && cyc_n < 500) begin
      bus.in_valid = ($urandom_range(99) < pct);
      drv = 48'({$urandom(), $urandom()});
      bus.in_pix = pix_pair_t'(drv);
      if (poke_start && k == 5) start = 1'b1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      cyc_n++;
      start = 1'b0;
      vecs++; if (bus.wr_hsync !== acc) begin errs++; $display("FAIL %s hsync k=%0d: got %b want %b", tag, k, bus.wr_hsync, acc); end
      if (acc) begin
        vecs++; if (bus.wr_row !== exp_row(k / ROW_PAIRS)) begin errs++; $display("FAIL %s row k=%0d: got %0d want %0d", tag, k, bus.wr_row, exp_row(k / ROW_PAIRS)); end
        vecs++; if (bus.wr_col !== COL_W'(k % ROW_PAIRS)) begin errs++; $display("FAIL %s col k=%0d: got %0d want %0d", tag, k, bus.wr_col, k % ROW_PAIRS); end
        vecs++; if (48'(bus.wr_pix) !== drv) begin errs++; $display("FAIL %s pix k=%0d: got %h want %h", tag, k, 48'(bus.wr_pix), drv); end
        k++;
        if (k % ROW_PAIRS == 0 && k < PAIRS) gap = HB;
      end
      vecs++; if (pc !== PC_W'(k)) begin errs++; $display("FAIL %s pair_count: got %0d want %0d", tag, pc, k); end
      if (abort_at != 0 && k == abort_at) return;
      if (k < PAIRS) begin
        vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL %s early_done k=%0d: got %b want 0", tag, k, frame_done); end
        vecs++; if (bus.in_ready !== (gap == 0)) begin errs++; $display("FAIL %s ready k=%0d: got %b want %b", tag, k, bus.in_ready, gap == 0); end
        if (gap > 0) gap--;
      end
    end
    bus.in_valid = 1'b0;
    vecs++; if (k != PAIRS) begin errs++; $display("FAIL %s timeout: got %0d pairs want %0d", tag, k, PAIRS); return; end
    vecs++; if ({busy, bus.in_ready, frame_done} !== 3'b100) begin errs++; $display("FAIL %s last_strobe busy/ready/done: got %b want 100", tag, {busy, bus.in_ready, frame_done}); end
    if (poke_start) start = 1'b1;
    tick();
    start = 1'b0;
    vecs++; if ({frame_done, busy, bus.wr_hsync} !== 3'b110) begin errs++; $display("FAIL %s done_cycle done/busy/hsync: got %b want 110", tag, {frame_done, busy, bus.wr_hsync}); end
    tick();
    vecs++; if ({frame_done, busy} !== 2'b00) begin errs++; $display("FAIL %s idle done/busy: got %b want 00", tag, {frame_done, busy}); end
    vecs++; if (pc !== PC_W'(PAIRS)) begin errs++; $display("FAIL %s final_count: got %0d want %0d", tag, pc, PAIRS); end
    tick();
    vecs++; if ({frame_done, busy, bus.in_ready} !== 3'b000) begin errs++; $display("FAIL %s stays_idle: got %b want 000", tag, {frame_done, busy, bus.in_ready}); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    bus.in_valid = 1'b0;  bus.in_pix = '0;
    bus0.in_valid = 1'b0; bus0.in_pix = '0;
    repeat (2) tick();
    vecs++; if ({busy, frame_done, bus.in_ready, bus.wr_hsync} !== 4'b0000) begin errs++; $display("FAIL reset flags: got %b want 0000", {busy, frame_done, bus.in_ready, bus.wr_hsync}); end
    vecs++; if (bus.wr_row !== exp_row(0)) begin errs++; $display("FAIL reset wr_row: got %0d want %0d", bus.wr_row, exp_row(0)); end
    vecs++; if ({bus.wr_col, 48'(bus.wr_pix), pc} !== '0) begin errs++; $display("FAIL reset col/pix/count: got %h want 0", {bus.wr_col, 48'(bus.wr_pix), pc}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_frame();
    run_frame(100, 1'b0, 0, "full");
  endtask

  task automatic test_random_valid();
    for (int f = 0; f < 3; f++) run_frame(55, 1'b0, 0, "rand");
  endtask

  task automatic test_start_ignored();
    run_frame(75, 1'b1, 0, "restart");
  endtask

  task automatic test_hreset_mid();
    run_frame(100, 1'b0, 6, "abort");
    #2 rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    vecs++; if ({busy, frame_done, bus.in_ready, bus.wr_hsync} !== 4'b0000) begin errs++; $display("FAIL abort flags: got %b want 0000", {busy, frame_done, bus.in_ready, bus.wr_hsync}); end
    vecs++; if (bus.wr_row !== exp_row(0) || bus.wr_col !== '0 || pc !== '0) begin errs++; $display("FAIL abort addr/count: got %0d/%0d/%0d want %0d/0/0", bus.wr_row, bus.wr_col, pc, exp_row(0)); end
    repeat (2) begin
      tick();
      vecs++; if (frame_done !== 1'b0) begin errs++; $display("FAIL abort frame_done: got %b want 0", frame_done); end
    end
    rst = 1'b0;
    tick();
    run_frame(100, 1'b0, 0, "after_abort");
  endtask

  task automatic test_no_hblank();
    logic [47:0] drv;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    bus0.in_valid = 1'b1;
    for (int i = 0; i < PAIRS; i++) begin
      drv = 48'({$urandom(), $urandom()});
      bus0.in_pix = pix_pair_t'(drv);
      tick();
      vecs++; if (bus0.wr_hsync !== 1'b1) begin errs++; $display("FAIL nogap hsync i=%0d: got %b want 1", i, bus0.wr_hsync); end
      vecs++; if (bus0.wr_row !== exp_row(i / ROW_PAIRS) || bus0.wr_col !== COL_W'(i % ROW_PAIRS)) begin errs++; $display("FAIL nogap addr i=%0d: got %0d/%0d want %0d/%0d", i, bus0.wr_row, bus0.wr_col, exp_row(i / ROW_PAIRS), i % ROW_PAIRS); end
      vecs++; if (48'(bus0.wr_pix) !== drv) begin errs++; $display("FAIL nogap pix i=%0d: got %h want %h", i, 48'(bus0.wr_pix), drv); end
    end
    bus0.in_valid = 1'b0;
    tick();
    vecs++; if ({frame_done0, bus0.wr_hsync} !== 2'b10) begin errs++; $display("FAIL nogap done/hsync: got %b want 10", {frame_done0, bus0.wr_hsync}); end
    tick();
    vecs++; if (busy0 !== 1'b0 || pc0 !== PC_W'(PAIRS)) begin errs++; $display("FAIL nogap end busy/count: got %b/%0d want 0/%0d", busy0, pc0, PAIRS); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_random_valid();
    test_start_ignored();
    test_hreset_mid();
    test_no_hblank();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/image_write_ctrl.md
# image_write_ctrl

Sequences pixel-pair traffic from the enhancement pipeline into the BMP frame writer. Accepts 48-bit pixel pairs over a valid/ready handshake and issues a registered write strobe (`wr_hsync`) with an explicit row/pair address. Inserts a programmable horizontal blanking gap after each row and pulses `frame_done` once a full frame has been written. Sits between the last filter stage and the image writer.

## Interface
Parameters:
- `WIDTH`, 768: image width in pixels; must be even.
- `HEIGHT`, 512: image height in rows.
- `HBLANK`, 4: idle cycles inserted after each row; 0 means no gap.
- `ROW_W`, `$clog2(HEIGHT)`: row address width (derived).
- `COL_W`, `$clog2(WIDTH/2)`: pair address width (derived).

Ports:
- `HCLK` in 1: clock, rising edge.
- `HRESET` in 1: reset, asynchronous, active-high.
- `start` in 1: pulse that begins a frame; ignored unless IDLE.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: controller can accept a pair.
- `in_pix` in 48: {R0,G0,B0,R1,G1,B1}; R0 is the odd (left) pixel.
- `wr_hsync` out 1: one-cycle write strobe to the writer.
- `wr_row` out ROW_W: row address of the current strobe.
- `wr_col` out COL_W: pair index within the row.
- `wr_pix` out 48: registered copy of the accepted `in_pix`.
- `busy` out 1: high whenever state ≠ IDLE.
- `frame_done` out 1: one-cycle pulse at end of frame.
- `pair_count` out `$clog2(WIDTH*HEIGHT/2+1)`: pairs written in the current frame.

## Operation
- FSM states and transitions:
  - IDLE → ACTIVE on `start`.
  - In ACTIVE, on an accepted pair (`in_valid & in_ready`):
    - Column < WIDTH/2−1: increment column.
    - Last column, not last row: column ← 0, row++, go to HBLANK (or stay in ACTIVE if `HBLANK`=0).
    - Last column of last row: go to DONE.
  - HBLANK counts `HBLANK` cycles, then returns to ACTIVE.
  - DONE lasts one cycle, then goes to IDLE.
- `in_ready = (state == ACTIVE)`. This is a combinational decode of a register with no path from `in_valid`.
- An accepted pair is registered into `wr_pix`/`wr_row`/`wr_col`, and `wr_hsync` is set to 1 for exactly one cycle. `pair_count` increments on the same edge.
- Column and row counters are unsigned and wrap to 0 on frame completion. `pair_count` saturates at WIDTH*HEIGHT/2.
- `start` while busy: ignored; it does not restart the frame.
- `start` on the DONE cycle: ignored.
- `in_valid` low in ACTIVE: hold the state and counters, with no strobe.
- On the IDLE→ACTIVE edge, clear `pair_count`, row, column and the blank counter.
- `HRESET` mid-frame: abort immediately and discard any partially written frame. `frame_done` must not fire.

## Timing
- Reset values: `in_ready`=0, `wr_hsync`=0, `wr_row`=0, `wr_col`=0, `wr_pix`=0, `busy`=0, `frame_done`=0, `pair_count`=0. Under `IMG_WR_CTRL_VFLIP_EN`, `wr_row` resets to HEIGHT−1.
- Start latency:
  - `start` sampled high at edge N gives `busy`=1 and `in_ready`=1 after edge N.
  - The earliest acceptance is at edge N+1.
- Write latency:
  - A pair accepted at edge T gives `wr_hsync`=1 with its address and data during the cycle after edge T.
  - Single-cycle latency; full throughput of 1 pair per cycle within a row.
- Row end: last pair accepted at edge T ⇒ `in_ready`=0 for exactly `HBLANK` cycles after T.
- Frame end: last pair accepted at edge T ⇒ `wr_hsync` asserted after T, `frame_done` asserted after T+1, `busy`=0 after T+2.

## Configuration
- `IMG_WR_CTRL_VFLIP_EN` defined: `wr_row` = HEIGHT−1−row. The first row received lands at the bottom address (BMP bottom-up storage).
- Not defined: `wr_row` = row (top-down order).
- All other behaviour is identical in both builds.

## Structure
- Shared package `image_pkg`:
  - `PIX_PAIR_W` = 48.
  - `pix_pair_t` packed struct (r0, g0, b0, r1, g1, b1).
  - `wr_ctrl_state_e` enum (IDLE, ACTIVE, HBLANK, DONE).
- One sub-module, `frame_pos_counter`: the column/row counter pair with last-column and last-row flags, plus the optional flip. The FSM and output registers live in the top level.

## Test plan
All scenarios use WIDTH=8, HEIGHT=4, HBLANK=2 unless stated.
- Reset, then `start` with `in_valid` held high ⇒ 16 strobes with (`wr_row`,`wr_col`) running (0,0)…(3,3). `frame_done` pulses 2 cycles after the last acceptance. Final `pair_count`=16.
- Row gap ⇒ `in_ready` is low for exactly 2 cycles after each of pairs 3, 7 and 11. With `HBLANK`=0 there are no gaps and 16 consecutive strobes.
- `in_valid` toggled pseudo-randomly ⇒ `wr_pix` sequence equals the accepted `in_pix` sequence. No strobe occurs when `in_valid`=0.
- `start` pulsed during the frame and on the DONE cycle ⇒ both ignored. Exactly one `frame_done`, and `pair_count` is not cleared.
- `HRESET` asserted after pair 6 ⇒ all outputs at reset values, no `frame_done`. A new `start` then restarts at (0,0).
- `IMG_WR_CTRL_VFLIP_EN` build ⇒ first strobe has `wr_row`=3 and the last strobe has `wr_row`=0.
